// File: rtl/sound_pkg.sv
// Shared sound definitions: note codes, pitch table, half-period helper,
// melody ROM contents and the melody player FSM states.
package sound_pkg;

    typedef enum logic [3:0] {
        NOTE_REST = 4'd0,
        NOTE_C4   = 4'd1,
        NOTE_CS4  = 4'd2,
        NOTE_D4   = 4'd3,
        NOTE_DS4  = 4'd4,
        NOTE_E4   = 4'd5,
        NOTE_F4   = 4'd6,
        NOTE_FS4  = 4'd7,
        NOTE_G4   = 4'd8,
        NOTE_GS4  = 4'd9,
        NOTE_A4   = 4'd10,
        NOTE_AS4  = 4'd11,
        NOTE_B4   = 4'd12,
        NOTE_C5   = 4'd13,
        NOTE_D5   = 4'd14,
        NOTE_E5   = 4'd15
    } note_t;

    typedef struct packed {
        note_t      note;
        logic [1:0] dur;
    } rom_entry_t;

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} mel_state_t;

    localparam int NUM_MEL = 4;
    localparam int ROM_LEN = 16;

    // Pitch in Hz per note code; index 0 is the rest.
    localparam int unsigned NOTE_HZ [16] = '{
        0, 262, 277, 294, 311, 330, 349, 370,
        392, 415, 440, 466, 494, 523, 587, 659
    };

    // clk_hz is always a parameter, so every branch folds to a constant and
    // the result is a small constant mux rather than a divider.
    function automatic logic [16:0] half_period(input int unsigned clk_hz,
                                                input logic [3:0]  code);
        logic [16:0] h;
        h = '0;
        for (int i = 1; i < 16; i++) begin
            if (code == 4'(i)) h = 17'(clk_hz / (2 * NOTE_HZ[i]));
        end
        return h;
    endfunction

    // Each melody is stored twice over so any MEL_LEN up to 16 reads valid notes.
    localparam rom_entry_t MEL_ROM [NUM_MEL][ROM_LEN] = '{
        '{'{NOTE_FS4, 2'd0}, '{NOTE_FS4, 2'd0}, '{NOTE_CS4, 2'd0}, '{NOTE_D4,  2'd0},
          '{NOTE_GS4, 2'd0}, '{NOTE_GS4, 2'd0}, '{NOTE_E4,  2'd0}, '{NOTE_FS4, 2'd0},
          '{NOTE_FS4, 2'd0}, '{NOTE_FS4, 2'd0}, '{NOTE_CS4, 2'd0}, '{NOTE_D4,  2'd0},
          '{NOTE_GS4, 2'd0}, '{NOTE_GS4, 2'd0}, '{NOTE_E4,  2'd0}, '{NOTE_FS4, 2'd0}},
        '{'{NOTE_C4,  2'd0}, '{NOTE_D4,  2'd1}, '{NOTE_E4,  2'd0}, '{NOTE_G4,  2'd2},
          '{NOTE_A4,  2'd0}, '{NOTE_B4,  2'd1}, '{NOTE_C5,  2'd0}, '{NOTE_E5,  2'd0},
          '{NOTE_C4,  2'd0}, '{NOTE_D4,  2'd1}, '{NOTE_E4,  2'd0}, '{NOTE_G4,  2'd2},
          '{NOTE_A4,  2'd0}, '{NOTE_B4,  2'd1}, '{NOTE_C5,  2'd0}, '{NOTE_E5,  2'd0}},
        '{'{NOTE_A4,  2'd0}, '{NOTE_REST, 2'd3}, '{NOTE_B4, 2'd0}, '{NOTE_D5,  2'd1},
          '{NOTE_F4,  2'd0}, '{NOTE_DS4, 2'd0}, '{NOTE_CS4, 2'd1}, '{NOTE_C4,  2'd0},
          '{NOTE_A4,  2'd0}, '{NOTE_REST, 2'd3}, '{NOTE_B4, 2'd0}, '{NOTE_D5,  2'd1},
          '{NOTE_F4,  2'd0}, '{NOTE_DS4, 2'd0}, '{NOTE_CS4, 2'd1}, '{NOTE_C4,  2'd0}},
        '{'{NOTE_A4,  2'd0}, '{NOTE_AS4, 2'd0}, '{NOTE_C5,  2'd0}, '{NOTE_E5,  2'd0},
          '{NOTE_REST, 2'd0}, '{NOTE_D5, 2'd0}, '{NOTE_B4,  2'd0}, '{NOTE_A4,  2'd1},
          '{NOTE_A4,  2'd0}, '{NOTE_AS4, 2'd0}, '{NOTE_C5,  2'd0}, '{NOTE_E5,  2'd0},
          '{NOTE_REST, 2'd0}, '{NOTE_D5, 2'd0}, '{NOTE_B4,  2'd0}, '{NOTE_A4,  2'd1}}
    };

endpackage

// File: rtl/melody_player_if.sv
// Control/status bundle between the game controller (master) and the
// melody player (slave), including the audio pin.
interface melody_player_if;
    logic [1:0] melSel;
    logic       melStart;
    logic       melStop;
    logic       toneOut;
    logic [3:0] noteCode;
    logic       busy;
    logic       done;

    modport master (
        output melSel, melStart, melStop,
        input  toneOut, noteCode, busy, done
    );

    modport slave (
        input  melSel, melStart, melStop,
        output toneOut, noteCode, busy, done
    );
endinterface

// File: rtl/tone_divider.sv
// Square-wave generator: toggles wave every half clocks while enabled;
// clear forces the counter and the wave low on the next edge.
module tone_divider (
    input  logic        clk,
    input  logic        resetN,
    input  logic        en,
    input  logic        clear,
    input  logic [16:0] half,
    output logic        wave
);

    logic [16:0] div_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            div_cnt <= '0;
            wave    <= 1'b0;
        end else if (clear) begin
            div_cnt <= '0;
            wave    <= 1'b0;
        end else if (en && (half != 17'd0)) begin
            if (div_cnt == half - 17'd1) begin
                div_cnt <= '0;
                wave    <= ~wave;
            end else begin
                div_cnt <= div_cnt + 17'd1;
            end
        end
    end

endmodule

// File: rtl/melody_player.sv
// Plays one of four ROM melodies as a square wave on toneOut.
// Define MELODY_LOOP_EN to make melody 3 repeat until stopped or restarted.
module melody_player
    import sound_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 31_500_000,
    parameter int unsigned NOTE_MS = 125,
    parameter int unsigned GAP_MS  = 10,
    parameter int unsigned MEL_LEN = 8
) (
    input  logic              clk,
    input  logic              resetN,
    melody_player_if.slave    bus
);

    localparam int unsigned TICK_DIV = CLK_HZ / 1000;
    localparam int          PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    mel_state_t       state;
    logic [1:0]       sel;
    logic [3:0]       idx;
    logic [PRE_W-1:0] pre;
    logic [9:0]       ms_cnt;
    logic [16:0]      half;
    rom_entry_t       entry;
    logic             tick;
    logic             last_ms;
    logic             last_note;
    logic             wrap;
    logic             keep_play;

    assign entry     = MEL_ROM[sel][idx];
    assign tick      = (pre == PRE_W'(TICK_DIV - 1));
    assign last_ms   = tick && (ms_cnt == 10'd1);
    assign last_note = (idx == 4'(MEL_LEN - 1));

`ifdef MELODY_LOOP_EN
    assign wrap = (sel == 2'd3);
`else
    assign wrap = 1'b0;
`endif

    // The divider runs only on PLAY cycles that stay in PLAY, so whatever
    // state follows already sees toneOut low on its first cycle.
    assign keep_play = (state == PLAY) && !bus.melStop && !bus.melStart && !last_ms;

    tone_divider u_div (
        .clk    (clk),
        .resetN (resetN),
        .en     (keep_play),
        .clear  (!keep_play),
        .half   (half),
        .wave   (bus.toneOut)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            sel          <= '0;
            idx          <= '0;
            pre          <= '0;
            ms_cnt       <= '0;
            half         <= '0;
            bus.noteCode <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            pre      <= tick ? '0 : pre + 1'b1;

            if (bus.melStop) begin
                state        <= IDLE;
                idx          <= '0;
                bus.noteCode <= '0;
                bus.busy     <= 1'b0;
            end else if (bus.melStart) begin
                sel          <= bus.melSel;
                idx          <= '0;
                state        <= LOAD;
                bus.noteCode <= '0;
                bus.busy     <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        half         <= half_period(CLK_HZ, entry.note);
                        ms_cnt       <= 10'((int'(entry.dur) + 1) * NOTE_MS);
                        pre          <= '0;
                        bus.noteCode <= entry.note;
                        state        <= PLAY;
                    end
                    PLAY: begin
                        if (tick) ms_cnt <= ms_cnt - 10'd1;
                        if (last_ms) begin
                            ms_cnt       <= 10'(GAP_MS);
                            pre          <= '0;
                            bus.noteCode <= '0;
                            state        <= GAP;
                        end
                    end
                    GAP: begin
                        if (tick) ms_cnt <= ms_cnt - 10'd1;
                        if (last_ms) begin
                            if (!last_note) begin
                                idx   <= idx + 4'd1;
                                state <= LOAD;
                            end else if (wrap) begin
                                idx   <= '0;
                                state <= LOAD;
                            end else begin
                                bus.done <= 1'b1;
                                state    <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player: stimulus pushes the expected per-cycle
// output trace of each melody, a monitor process pops and compares it.
module tb_melody_player;

    localparam int CLK_HZ  = 10_000;
    localparam int NOTE_MS = 2;
    localparam int GAP_MS  = 1;
    localparam int MEL_LEN = 8;
    localparam int TICK    = CLK_HZ / 1000;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] code;
        logic       tone;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];

    int tb_hz [16] = '{0, 262, 277, 294, 311, 330, 349, 370,
                       392, 415, 440, 466, 494, 523, 587, 659};
    int tb_note [4][8] = '{'{7, 7, 2, 3, 9, 9, 5, 7},
                           '{1, 3, 5, 8, 10, 12, 13, 15},
                           '{10, 0, 12, 14, 6, 4, 2, 1},
                           '{10, 11, 13, 15, 0, 14, 12, 10}};
    int tb_dur [4][8]  = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                           '{0, 1, 0, 2, 0, 1, 0, 0},
                           '{0, 3, 0, 1, 0, 0, 1, 0},
                           '{0, 0, 0, 0, 0, 0, 0, 1}};

    melody_player_if bus ();

    melody_player #(
        .CLK_HZ  (CLK_HZ),
        .NOTE_MS (NOTE_MS),
        .GAP_MS  (GAP_MS),
        .MEL_LEN (MEL_LEN)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(bit b, bit d, int c, bit t);
        exp_t e;
        e.busy = b;
        e.done = d;
        e.code = 4'(c);
        e.tone = t;
        return e;
    endfunction

    function automatic exp_t observed();
        return mk(bus.busy, bus.done, int'(bus.noteCode), bus.toneOut);
    endfunction

    task automatic check(string name, exp_t g, exp_t w);
        n_checks++;
        if (g === w) n_pass++;
        else $display("FAIL %s at %0t: got busy=%b done=%b note=%0d tone=%b, want busy=%b done=%b note=%0d tone=%b",
                      name, $time, g.busy, g.done, g.code, g.tone, w.busy, w.done, w.code, w.tone);
    endtask

    task automatic check_int(string name, int g, int w);
        n_checks++;
        if (g == w) n_pass++;
        else $display("FAIL %s at %0t: got %0d, want %0d", name, $time, g, w);
    endtask

    // One note: a silent load cycle, the sounding part, then the silent gap.
    task automatic push_note(int s, int i);
        int n, len, h;
        bit t;
        n   = tb_note[s][i];
        len = (tb_dur[s][i] + 1) * NOTE_MS * TICK;
        h   = (n == 0) ? 0 : CLK_HZ / (2 * tb_hz[n]);
        q.push_back(mk(1, 0, 0, 0));
        for (int c = 0; c < len; c++) begin
            t = 1'b0;
            if (n != 0) t = ((c / h) % 2) == 1;
            q.push_back(mk(1, 0, n, t));
        end
        for (int c = 0; c < GAP_MS * TICK; c++) q.push_back(mk(1, 0, 0, 0));
    endtask

    task automatic push_melody(int s);
        int passes;
        passes = 1;
`ifdef MELODY_LOOP_EN
        if (s == 3) passes = 3;
`endif
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < MEL_LEN; i++) push_note(s, i);
        if (passes == 1) q.push_back(mk(1, 1, 0, 0));
    endtask

    // The front entry belongs to the cycle in which the command is driven;
    // the command takes effect from the following cycle.
    task automatic do_cmd(bit st, bit sp, int s);
        exp_t keep;
        @(posedge clk);
        #1;
        bus.melSel   = 2'(s);
        bus.melStart = st;
        bus.melStop  = sp;
        if (q.size() > 0) begin
            keep = q[0];
            q.delete();
            q.push_back(keep);
        end else begin
            q.push_back(mk(0, 0, 0, 0));
        end
        if (st && !sp) push_melody(s);
        @(posedge clk);
        #1;
        bus.melStart = 1'b0;
        bus.melStop  = 1'b0;
    endtask

    task automatic wait_idle(int max_cycles);
        int n;
        n = 0;
        while (q.size() > 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        check_int("drain_timeout", q.size(), 0);
        q.delete();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bus.melSel   = 2'd0;
        bus.melStart = 1'b0;
        bus.melStop  = 1'b0;

        #12;
        check("reset_values", observed(), mk(0, 0, 0, 0));
        @(posedge clk);
        #1;
        resetN = 1'b1;
        mon_en = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (mon_en && resetN) begin
                    exp_t e;
                    e = (q.size() > 0) ? q.pop_front() : mk(0, 0, 0, 0);
                    check("cycle", observed(), e);
                end
            end
        join_none

        // Each melody played to its natural end.
        do_cmd(1, 0, 0); wait_idle(2000);
        do_cmd(1, 0, 1); wait_idle(2000);
        do_cmd(1, 0, 2); wait_idle(2000);
        do_cmd(1, 0, 3);
`ifdef MELODY_LOOP_EN
        repeat (2 * 268 + 40) @(posedge clk);
        do_cmd(0, 1, 0);
`endif
        wait_idle(2000);

        // Stop mid-PLAY of note 2; start+stop together from IDLE.
        do_cmd(1, 0, 0); repeat (48) @(posedge clk); do_cmd(0, 1, 0); wait_idle(2000);
        do_cmd(1, 1, 2); wait_idle(2000);

        // Restart with melody 2 during note 4 of melody 0.
        do_cmd(1, 0, 0); repeat (95) @(posedge clk); do_cmd(1, 0, 2); wait_idle(2000);

        for (int r = 0; r < 10; r++) begin
            int s, k, cur;
            s   = int'($urandom_range(0, 3));
            cur = s;
            do_cmd(1, 0, s);
            repeat ($urandom_range(5, 300)) @(posedge clk);
            k = int'($urandom_range(0, 3));
            s = int'($urandom_range(0, 3));
            case (k)
                0: do_cmd(0, 1, s);
                1: begin do_cmd(1, 0, s); cur = s; end
                2: do_cmd(1, 1, s);
                default: ;
            endcase
`ifdef MELODY_LOOP_EN
            if (cur == 3) begin
                repeat ($urandom_range(0, 60)) @(posedge clk);
                do_cmd(0, 1, 0);
            end
`endif
            wait_idle(3000);
        end

        // Asynchronous reset while A4 is high.
        do_cmd(1, 0, 3);
        repeat (13) @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset", observed(), mk(0, 0, 0, 0));
        q.delete();
        repeat (2) @(posedge clk);
        #2;
        resetN = 1'b1;
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
